// File: rtl/led_pwm_wb.sv
// Wishbone-mapped N-channel LED sequencer: per-channel on/off blink or counted burst,
// all channels paced by one shared free-running tick prescaler.
`timescale 1ns/1ps
module led_pwm_wb #(
  parameter int N   = 3,
  parameter int CW  = 11,
  parameter int DIV = 12000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    wb_addr,
  input  logic [31:0]   wb_wdata,
  output logic [31:0]   wb_rdata,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  output logic [N-1:0]  led
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_DONE} state_t;

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          r_ack;
  logic [31:0]   r_rdata;
  logic [31:0]   w_rd;
  logic          w_wr;
  logic [N-1:0]  r_led;
  logic [N-1:0]  w_nled;
  logic [N-1:0]  r_ena;
  logic [N-1:0]  r_burst;
  logic [7:0]    r_cnt [N];
  logic [7:0]    r_bc  [N];
  logic [7:0]    w_nbc [N];
  logic [CW-1:0] r_on  [N];
  logic [CW-1:0] r_off [N];
  logic [CW-1:0] r_ph  [N];
  logic [CW-1:0] w_nph [N];
  state_t        r_st  [N];
  state_t        w_nst [N];
  logic          w_unused_wdata;

  assign w_tick         = (r_presc == '0);
  assign w_wr           = wb_cyc & wb_we & r_ack;
  assign wb_ack         = r_ack;
  assign wb_rdata       = r_rdata;
  assign led            = r_led;
  assign w_unused_wdata = &{1'b0, wb_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_presc <= PRE_MAX;
    else     r_presc <= w_tick ? PRE_MAX : r_presc - 1'b1;
  end

  // A restart always wins over a coincident tick; a finished OFF phase
  // (or a skipped zero-length one) funnels through the burst bookkeeping.
  always_comb begin : p_fsm
    logic       mode_hit, rs, rs_ena, rs_burst, do_on, do_eoff;
    logic [7:0] rs_cnt;
    w_nled = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_nst[i] = r_st[i];
      w_nph[i] = r_ph[i];
      w_nbc[i] = r_bc[i];
      mode_hit = w_wr && (wb_addr == 4'(3 + 2 * i));
      rs       = mode_hit || (w_wr && (wb_addr == 4'd1) && wb_wdata[i]);
      rs_ena   = mode_hit ? wb_wdata[31]  : r_ena[i];
      rs_burst = mode_hit ? wb_wdata[30]  : r_burst[i];
      rs_cnt   = mode_hit ? wb_wdata[7:0] : r_cnt[i];
      do_on    = 1'b0;
      do_eoff  = 1'b0;
      if (rs) begin
        if (!rs_ena) begin
          w_nst[i] = ST_IDLE;
          w_nph[i] = '0;
          w_nbc[i] = '0;
        end else if (rs_burst && (rs_cnt == 8'd0)) begin
          w_nst[i] = ST_DONE;
          w_nph[i] = '0;
          w_nbc[i] = '0;
        end else begin
          w_nbc[i] = rs_cnt;
          do_on    = 1'b1;
        end
      end else if (w_tick) begin
        case (r_st[i])
          ST_ON: begin
            if (r_ph[i] > CW'(1)) begin
              w_nph[i] = r_ph[i] - 1'b1;
            end else if ((r_on[i] == '0) && (r_off[i] == '0)) begin
              w_nph[i] = '0;
            end else if (r_off[i] != '0) begin
              w_nst[i] = ST_OFF;
              w_nph[i] = r_off[i];
            end else begin
              do_eoff = 1'b1;
            end
          end
          ST_OFF: begin
            if (r_ph[i] > CW'(1)) w_nph[i] = r_ph[i] - 1'b1;
            else                  do_eoff  = 1'b1;
          end
          default: ;
        endcase
      end
      if (do_eoff) begin
        if (r_burst[i]) begin
          w_nbc[i] = r_bc[i] - 1'b1;
          if (r_bc[i] == 8'd1) begin
            w_nst[i] = ST_DONE;
            w_nph[i] = '0;
          end else begin
            do_on = 1'b1;
          end
        end else begin
          do_on = 1'b1;
        end
      end
      if (do_on) begin
        if (r_on[i] != '0) begin
          w_nst[i] = ST_ON;
          w_nph[i] = r_on[i];
        end else if (r_off[i] != '0) begin
          w_nst[i] = ST_OFF;
          w_nph[i] = r_off[i];
        end else begin
          w_nst[i] = ST_ON;
          w_nph[i] = '0;
        end
      end
      w_nled[i] = (w_nst[i] == ST_ON) && (w_nph[i] != '0);
    end
  end

  always_comb begin
    w_rd = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (wb_addr == 4'd0) begin
        w_rd[i]      = r_led[i];
        w_rd[8 + i]  = (r_st[i] == ST_ON) || (r_st[i] == ST_OFF);
        w_rd[16 + i] = (r_st[i] == ST_DONE);
      end
      if (wb_addr == 4'(2 + 2 * i)) begin
        w_rd[CW+15:16] = r_off[i];
        w_rd[CW-1:0]   = r_on[i];
      end
      if (wb_addr == 4'(3 + 2 * i)) begin
        w_rd[31]  = r_ena[i];
        w_rd[30]  = r_burst[i];
        w_rd[7:0] = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= wb_cyc & ~r_ack;
      r_rdata <= (wb_cyc & ~r_ack) ? w_rd : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led   <= '0;
      r_ena   <= '0;
      r_burst <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
        r_bc[i]  <= '0;
        r_on[i]  <= '0;
        r_off[i] <= '0;
        r_ph[i]  <= '0;
        r_st[i]  <= ST_IDLE;
      end
    end else begin
      r_led <= w_nled;
      for (int unsigned i = 0; i < N; i++) begin
        if (w_wr && (wb_addr == 4'(2 + 2 * i))) begin
          r_on[i]  <= wb_wdata[CW-1:0];
          r_off[i] <= wb_wdata[CW+15:16];
        end
        if (w_wr && (wb_addr == 4'(3 + 2 * i))) begin
          r_ena[i]   <= wb_wdata[31];
          r_burst[i] <= wb_wdata[30];
          r_cnt[i]   <= wb_wdata[7:0];
        end
        r_st[i] <= w_nst[i];
        r_ph[i] <= w_nph[i];
        r_bc[i] <= w_nbc[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_wb.sv
// Directed bench for led_pwm_wb (N=3, CW=11, DIV=4): register table, blink timing,
// burst, zero-length phases, tick collisions and bus handshake.
`timescale 1ns/1ps
module tb_led_pwm_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic [31:0] wb_rdata;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack;
  logic [2:0]  led;

  int n_checks = 0;
  int n_err    = 0;

  led_pwm_wb #(.N(3), .CW(11), .DIV(4)) dut (
    .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(wb_rdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    int k = 0;
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
    do begin @(negedge clk); k++; end while (!wb_ack && k < 4);
    chk("wr_ack", {31'b0, wb_ack}, 32'd1);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    int k = 0;
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
    do begin @(negedge clk); k++; end while (!wb_ack && k < 4);
    chk("rd_ack", {31'b0, wb_ack}, 32'd1);
    d = wb_rdata;
    wb_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    while (led[ch] === lvl && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic wait_level(input int ch, input logic lvl);
    int k = 0;
    while (led[ch] !== lvl && k < 100) begin @(negedge clk); k++; end
    chk("wait_level", {31'b0, led[ch]}, {31'b0, lvl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n, pulses, highs, lows;
    logic prev;

    vecs[0]  = '{4'd0,  1'b0, 32'h0,         32'h0};
    vecs[1]  = '{4'd2,  1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[2]  = '{4'd2,  1'b0, 32'h0,         32'h07FF_07FF};
    vecs[3]  = '{4'd3,  1'b1, 32'h3FFF_FF12, 32'h0};
    vecs[4]  = '{4'd3,  1'b0, 32'h0,         32'h0000_0012};
    vecs[5]  = '{4'd7,  1'b1, 32'h4000_00AB, 32'h0};
    vecs[6]  = '{4'd7,  1'b0, 32'h0,         32'h4000_00AB};
    vecs[7]  = '{4'd1,  1'b0, 32'h0,         32'h0};
    vecs[8]  = '{4'd8,  1'b1, 32'h0000_1234, 32'h0};
    vecs[9]  = '{4'd8,  1'b0, 32'h0,         32'h0};
    vecs[10] = '{4'd0,  1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{4'd0,  1'b0, 32'h0,         32'h0};
    vecs[12] = '{4'd4,  1'b1, 32'h0005_0003, 32'h0};
    vecs[13] = '{4'd4,  1'b0, 32'h0,         32'h0005_0003};
    vecs[14] = '{4'd15, 1'b0, 32'h0,         32'h0};
    vecs[15] = '{4'd5,  1'b0, 32'h0,         32'h0};

    #1;
    chk("rst_led",   {29'b0, led},    32'h0);
    chk("rst_ack",   {31'b0, wb_ack}, 32'h0);
    chk("rst_rdata", wb_rdata,        32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) wb_write(vecs[i].addr, vecs[i].wdata);
      else begin
        wb_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // free-running blink on channel 0: on=2, off=3 ticks of 4 cycles
    wb_write(4'd2, 32'h0003_0002);
    wb_write(4'd3, 32'h8000_0000);
    chk("blink_latency", {31'b0, led[0]}, 32'd1);
    run_len(0, 1'b1, n);
    run_len(0, 1'b0, n); chk("blink_low1",  n, 12);
    run_len(0, 1'b1, n); chk("blink_high",  n, 8);
    run_len(0, 1'b0, n); chk("blink_low2",  n, 12);
    wb_read(4'd0, rd);
    chk("blink_status", rd & 32'h0001_0100, 32'h0000_0100);

    // asynchronous reset mid-blink
    wait_level(0, 1'b1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_led", {29'b0, led}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_read(4'd0, rd); chk("rst_mid_status", rd, 32'h0);
    wb_read(4'd3, rd); chk("rst_mid_mode0",  rd, 32'h0);
    wb_read(4'd2, rd); chk("rst_mid_time0",  rd, 32'h0);

    wb_write(4'd2, 32'h0003_0002);
    wb_write(4'd3, 32'h8000_0000);

    // burst of 3 on channel 1, then CTRL restart
    wb_write(4'd4, 32'h0001_0001);
    chk("burst_pre", {31'b0, led[1]}, 32'd0);
    wb_write(4'd5, 32'hC000_0003);
    chk("burst_latency", {31'b0, led[1]}, 32'd1);
    pulses = 1; prev = 1'b1;
    repeat (60) begin @(negedge clk); if (led[1] && !prev) pulses++; prev = led[1]; end
    chk("burst_pulses", pulses, 3);
    wb_read(4'd0, rd);
    chk("burst_done", rd & 32'h0002_0202, 32'h0002_0000);
    wb_write(4'd1, 32'h0000_0002);
    chk("ctrl_latency", {31'b0, led[1]}, 32'd1);
    pulses = 1; prev = 1'b1;
    repeat (60) begin @(negedge clk); if (led[1] && !prev) pulses++; prev = led[1]; end
    chk("ctrl_pulses", pulses, 3);

    // zero-length phases on channel 2
    wb_write(4'd6, 32'h0003_0000);
    wb_write(4'd7, 32'h8000_0000);
    highs = 0;
    repeat (40) begin @(negedge clk); if (led[2]) highs++; end
    chk("on0_highs", highs, 0);
    wb_read(4'd0, rd);
    chk("on0_busy", rd & 32'h0004_0404, 32'h0000_0400);
    wb_write(4'd6, 32'h0000_0005);
    wb_write(4'd7, 32'h8000_0000);
    lows = 0;
    repeat (60) begin if (!led[2]) lows++; @(negedge clk); end
    chk("off0_lows", lows, 0);
    wb_write(4'd7, 32'hC000_0000);
    chk("cnt0_led", {31'b0, led[2]}, 32'd0);
    wb_read(4'd0, rd);
    chk("cnt0_done", rd & 32'h0004_0404, 32'h0004_0000);
    wb_write(4'd6, 32'h0000_0000);
    wb_write(4'd7, 32'hC000_0002);
    repeat (40) @(negedge clk);
    wb_read(4'd0, rd);
    chk("park_busy", rd & 32'h0004_0404, 32'h0000_0400);

    // MODE write committing on a tick edge (tick edges = channel 0 transitions)
    wb_write(4'd4, 32'h0003_0002);
    wait_level(0, 1'b1);
    wait_level(0, 1'b0);
    @(negedge clk); @(negedge clk);
    wb_write(4'd5, 32'h8000_0000);
    chk("coll_latency", {31'b0, led[1]}, 32'd1);
    run_len(1, 1'b1, n); chk("coll_high", n, 8);
    wb_write(4'd4, 32'h0001_0001);
    run_len(1, 1'b0, n); chk("timewr_low_rest", n, 10);
    run_len(1, 1'b1, n); chk("timewr_high_new", n, 4);
    run_len(1, 1'b0, n); chk("timewr_low_new",  n, 4);

    // back-to-back cycles: ack every other cycle, rdata only with ack
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 4'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack%0d", k), {31'b0, wb_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_rdata%0d", k), wb_rdata, (k % 2 == 0) ? 32'h0003_0002 : 32'h0);
    end
    wb_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ack",   {31'b0, wb_ack}, 32'd0);
    chk("idle_rdata", wb_rdata,        32'h0);
    wb_read(4'd15, rd); chk("unmapped15", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
